sfdbs_err_logger: RTL and testbench
===================================

Name: sfdbs_err_logger

Overview:
- Hardware-side writer for the sfdbs0 error log registers (err_log, err_data, err_idx). It drives the _d/_enb fields of these registers and watches their _q values.
- Collects error events from the doorbell slices and picks one winner per cycle. The winner is captured into the log only if the log is empty; later errors set the multi flag.
- Keeps a saturating count of all error events. Sits between the slice datapaths and the sfdbs0 register block.

Parameters:
- NUM_SLICES, 32, number of error sources; slice index width is $clog2(NUM_SLICES) and must be 5 or less.
- CNT_W, 16, width of the saturating error-event counter.

Ports:
- clk  input  1  block clock
- rst  input  1  synchronous, active-high reset
- err_vld  input  NUM_SLICES  per-slice error strobe, one-cycle pulse per event
- err_code  input  NUM_SLICES*3  per-slice error code; slice i uses bits [3i+2:3i]
- err_access  input  NUM_SLICES  per-slice access type: 0 = read, 1 = write
- err_id  input  NUM_SLICES*6  per-slice requester id
- err_data  input  NUM_SLICES*32  per-slice faulting data/address
- err_group  input  NUM_SLICES*4  per-slice group index
- code_q  input  3  err_log.code current value; 0 means the log is empty
- multi_q  input  1  err_log.multi current value
- code_d, access_d, id_d, multi_d  output  3/1/6/1  err_log write data
- code_enb, access_enb, id_enb, multi_enb  output  1 each  err_log write enables
- data_d  output  32  err_data write data
- data_enb  output  1  err_data write enable
- slice_idx_d  output  5  err_idx.slice_idx write data
- group_idx_d  output  4  err_idx.group_idx write data
- slice_idx_enb, group_idx_enb  output  1  err_idx write enables
- cnt_clr  input  1  clears err_cnt
- err_cnt  output  CNT_W  saturating count of error events

Behaviour:
- All outputs are registered.
- Reset values: all _d outputs 0, all _enb outputs 0, err_cnt 0. FSM goes to IDLE and multi_pend is cleared.
- Arbitration: among the asserted err_vld bits, the lowest index wins. The number of asserted bits in a cycle is nvld.
- A winning code of 0 is logged as 3'd7 (unknown), so a captured log is never read as empty.
- FSM states and transitions:
  - IDLE: log is empty.
    - If nvld>0 in cycle N: the next cycle (N+1) pulses every enable except multi_enb for exactly one cycle, with the winner's fields.
    - In that same cycle, multi_enb=1 with multi_d=(nvld>1); this clears any stale multi.
    - Go to WAIT.
  - WAIT: hold until code_q!=0, then go to FULL. Enables are 0 in this state.
    - Any err_vld seen here sets multi_pend.
  - FULL: log is occupied.
    - err_vld or multi_pend with multi_q==0: pulse multi_enb=1, multi_d=1 for one cycle, then clear multi_pend.
    - err_vld with multi_q==1: no write.
    - code_q==0 (software cleared the log): go to IDLE.
    - code_q==0 and err_vld in the same cycle: treat as IDLE, i.e. capture the new error and go to WAIT. No event is lost.
- Enables are never held longer than one cycle.
- The logger never writes the capture fields while the log is non-empty; the first error's fields are preserved.
- Counter:
  - err_cnt increases by nvld each cycle and saturates at all-ones.
  - cnt_clr takes priority: err_cnt becomes 0 and events in that cycle are dropped.
- rst during WAIT/FULL: FSM goes to IDLE and multi_pend is cleared. If the log is still occupied after reset, the first error is treated as IDLE capture only once code_q reads 0. The check is made in IDLE: if code_q!=0, go directly to FULL without writing.

Decomposition:
- Package sfdbs_err_pkg holds:
  - constants ERR_CODE_NONE=3'd0 and ERR_CODE_UNKNOWN=3'd7;
  - the enum for the FSM states {IDLE, WAIT, FULL};
  - struct err_rec_t {code, access, id, data, group, slice}.
- One sub-module, sfdbs_err_arb: combinational lowest-index priority select plus popcount. It outputs err_rec_t, any_vld and nvld.

Test Plan:
- Single error: slice 3, code 2, write access, id 0x15, data 0xDEADBEEF, group 5. Expected: one-cycle pulse of all enables with those values and slice_idx 3; multi_d=0; err_cnt=1.
- Simultaneous errors on slices 7 and 2. Expected: slice 2 is logged; multi_d=1; err_cnt=2.
- Error while FULL with multi_q=0. Expected: a single multi_enb pulse with multi_d=1 and no other enables; a second error after that produces no write.
- Error arriving in WAIT: fires one cycle after capture, before code_q updates. Expected: multi_pend is set and multi_enb pulses upon entering FULL.
- Software clear (code_q goes to 0) in the same cycle as an error on slice 9. Expected: slice 9 is captured the next cycle.
- Counter: 0xFFFE plus 3 events gives 0xFFFF. cnt_clr together with an event gives 0.

Source files
------------

// File: rtl/sfdbs_err_logger_pkg.sv
// rtl/sfdbs_err_logger_pkg.sv - shared types and constants for the sfdbs0 error logger
package sfdbs_err_pkg;

  localparam int SLICE_W = 5;

  localparam logic [2:0] ERR_CODE_NONE    = 3'd0;
  localparam logic [2:0] ERR_CODE_UNKNOWN = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]         code;
    logic               access;
    logic [5:0]         id;
    logic [31:0]        data;
    logic [3:0]         group;
    logic [SLICE_W-1:0] slice;
  } err_rec_t;

endpackage

// File: rtl/sfdbs_err_logger_if.sv
// rtl/sfdbs_err_logger_if.sv - slice error sources and sfdbs0 log register hardware-write bus
interface sfdbs_err_logger_if #(
  parameter int NUM_SLICES = 32
);
  logic [NUM_SLICES-1:0]    err_vld;
  logic [NUM_SLICES*3-1:0]  err_code;
  logic [NUM_SLICES-1:0]    err_access;
  logic [NUM_SLICES*6-1:0]  err_id;
  logic [NUM_SLICES*32-1:0] err_data;
  logic [NUM_SLICES*4-1:0]  err_group;

  logic [2:0]  code_q;
  logic        multi_q;

  logic [2:0]  code_d;
  logic        access_d;
  logic [5:0]  id_d;
  logic        multi_d;
  logic        code_enb;
  logic        access_enb;
  logic        id_enb;
  logic        multi_enb;
  logic [31:0] data_d;
  logic        data_enb;
  logic [4:0]  slice_idx_d;
  logic [3:0]  group_idx_d;
  logic        slice_idx_enb;
  logic        group_idx_enb;

  modport master (
    input  err_vld, err_code, err_access, err_id, err_data, err_group,
    input  code_q, multi_q,
    output code_d, access_d, id_d, multi_d,
    output code_enb, access_enb, id_enb, multi_enb,
    output data_d, data_enb, slice_idx_d, group_idx_d, slice_idx_enb, group_idx_enb
  );

  modport slave (
    output err_vld, err_code, err_access, err_id, err_data, err_group,
    output code_q, multi_q,
    input  code_d, access_d, id_d, multi_d,
    input  code_enb, access_enb, id_enb, multi_enb,
    input  data_d, data_enb, slice_idx_d, group_idx_d, slice_idx_enb, group_idx_enb
  );
endinterface

// File: rtl/sfdbs_err_arb.sv
// rtl/sfdbs_err_arb.sv - lowest-index error select and event popcount
module sfdbs_err_arb
  import sfdbs_err_pkg::*;
#(
  parameter int NUM_SLICES = 32,
  parameter int NVLD_W     = $clog2(NUM_SLICES + 1)
) (
  input  logic [NUM_SLICES-1:0]    err_vld,
  input  logic [NUM_SLICES*3-1:0]  err_code,
  input  logic [NUM_SLICES-1:0]    err_access,
  input  logic [NUM_SLICES*6-1:0]  err_id,
  input  logic [NUM_SLICES*32-1:0] err_data,
  input  logic [NUM_SLICES*4-1:0]  err_group,
  output err_rec_t                 rec,
  output logic                     any_vld,
  output logic [NVLD_W-1:0]        nvld
);

  always_comb begin
    rec     = '0;
    any_vld = 1'b0;
    nvld    = '0;
    // Walk downward so the lowest asserted index is the last one written.
    for (int i = NUM_SLICES - 1; i >= 0; i--) begin
      if (err_vld[i]) begin
        any_vld    = 1'b1;
        rec.code   = err_code[3*i +: 3];
        rec.access = err_access[i];
        rec.id     = err_id[6*i +: 6];
        rec.data   = err_data[32*i +: 32];
        rec.group  = err_group[4*i +: 4];
        rec.slice  = SLICE_W'(i);
      end
    end
    for (int i = 0; i < NUM_SLICES; i++) begin
      nvld = nvld + NVLD_W'(err_vld[i]);
    end
  end

endmodule

// File: rtl/sfdbs_err_logger.sv
// rtl/sfdbs_err_logger.sv - captures the first slice error into the sfdbs0 log and counts events
module sfdbs_err_logger
  import sfdbs_err_pkg::*;
#(
  parameter int NUM_SLICES = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  sfdbs_err_logger_if.master    bus,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam int NVLD_W = $clog2(NUM_SLICES + 1);

  err_rec_t          rec;
  logic              any_vld;
  logic [NVLD_W-1:0] nvld;

  state_t state, nxt_state;
  logic   multi_pend, nxt_multi_pend;
  logic   cap, set_multi;
  logic   log_empty;
  logic [CNT_W:0] cnt_sum;

  sfdbs_err_arb #(.NUM_SLICES(NUM_SLICES), .NVLD_W(NVLD_W)) u_arb (
    .err_vld    (bus.err_vld),
    .err_code   (bus.err_code),
    .err_access (bus.err_access),
    .err_id     (bus.err_id),
    .err_data   (bus.err_data),
    .err_group  (bus.err_group),
    .rec        (rec),
    .any_vld    (any_vld),
    .nvld       (nvld)
  );

  assign log_empty = (bus.code_q == ERR_CODE_NONE);

  always_comb begin
    nxt_state      = state;
    nxt_multi_pend = multi_pend;
    cap            = 1'b0;
    set_multi      = 1'b0;
    case (state)
      IDLE: begin
        // A log left occupied across reset is adopted as-is, never overwritten.
        if (!log_empty) begin
          nxt_state      = FULL;
          nxt_multi_pend = multi_pend | any_vld;
        end else if (any_vld) begin
          cap            = 1'b1;
          nxt_multi_pend = 1'b0;
          nxt_state      = WAIT;
        end
      end
      WAIT: begin
        nxt_multi_pend = multi_pend | any_vld;
        if (!log_empty) nxt_state = FULL;
      end
      FULL: begin
        if (log_empty) begin
          nxt_multi_pend = 1'b0;
          if (any_vld) begin
            cap       = 1'b1;
            nxt_state = WAIT;
          end else begin
            nxt_state = IDLE;
          end
        end else if (bus.multi_q) begin
          nxt_multi_pend = 1'b0;
        end else if ((any_vld || multi_pend) && !bus.multi_enb) begin
          // multi_enb high means a multi write is already in flight.
          set_multi      = 1'b1;
          nxt_multi_pend = 1'b0;
        end else begin
          nxt_multi_pend = multi_pend | any_vld;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign cnt_sum = {1'b0, err_cnt} + (CNT_W+1)'(nvld);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      multi_pend        <= 1'b0;
      err_cnt           <= '0;
      bus.code_d        <= '0;
      bus.access_d      <= 1'b0;
      bus.id_d          <= '0;
      bus.multi_d       <= 1'b0;
      bus.code_enb      <= 1'b0;
      bus.access_enb    <= 1'b0;
      bus.id_enb        <= 1'b0;
      bus.multi_enb     <= 1'b0;
      bus.data_d        <= '0;
      bus.data_enb      <= 1'b0;
      bus.slice_idx_d   <= '0;
      bus.group_idx_d   <= '0;
      bus.slice_idx_enb <= 1'b0;
      bus.group_idx_enb <= 1'b0;
    end else begin
      state      <= nxt_state;
      multi_pend <= nxt_multi_pend;

      if (cnt_clr)            err_cnt <= '0;
      else if (cnt_sum[CNT_W]) err_cnt <= '1;
      else                    err_cnt <= cnt_sum[CNT_W-1:0];

      bus.code_enb      <= cap;
      bus.access_enb    <= cap;
      bus.id_enb        <= cap;
      bus.data_enb      <= cap;
      bus.slice_idx_enb <= cap;
      bus.group_idx_enb <= cap;
      bus.multi_enb     <= cap | set_multi;

      bus.code_d      <= cap ? ((rec.code == ERR_CODE_NONE) ? ERR_CODE_UNKNOWN : rec.code) : '0;
      bus.access_d    <= cap & rec.access;
      bus.id_d        <= cap ? rec.id : '0;
      bus.data_d      <= cap ? rec.data : '0;
      bus.slice_idx_d <= cap ? rec.slice : '0;
      bus.group_idx_d <= cap ? rec.group : '0;
      bus.multi_d     <= set_multi | (cap & (nvld > NVLD_W'(1)));
    end
  end

endmodule

// File: tb/tb_sfdbs_err_logger.sv
// tb/tb_sfdbs_err_logger.sv - directed self-checking bench for sfdbs_err_logger
module tb_sfdbs_err_logger;

  logic        clk = 1'b0;
  logic        rst;
  logic        cnt_clr;
  logic [15:0] err_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  sfdbs_err_logger_if #(.NUM_SLICES(32)) intf ();

  sfdbs_err_logger #(.NUM_SLICES(32), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (intf.master),
    .cnt_clr (cnt_clr),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_err();
    intf.err_vld    = '0;
    intf.err_code   = '0;
    intf.err_access = '0;
    intf.err_id     = '0;
    intf.err_data   = '0;
    intf.err_group  = '0;
  endtask

  task automatic set_err(input int s, input logic [2:0] code, input logic acc,
                         input logic [5:0] id, input logic [31:0] data, input logic [3:0] grp);
    intf.err_vld[s]           = 1'b1;
    intf.err_code[3*s +: 3]   = code;
    intf.err_access[s]        = acc;
    intf.err_id[6*s +: 6]     = id;
    intf.err_data[32*s +: 32] = data;
    intf.err_group[4*s +: 4]  = grp;
  endtask

  task automatic check_capture(input string tag, input logic [2:0] code, input logic acc,
                               input logic [5:0] id, input logic [31:0] data, input logic [3:0] grp,
                               input logic [4:0] slice, input logic multi);
    check({tag, "_code_enb"},  {31'd0, intf.code_enb}, 32'd1);
    check({tag, "_data_enb"},  {31'd0, intf.data_enb}, 32'd1);
    check({tag, "_idx_enb"},   {30'd0, intf.slice_idx_enb, intf.group_idx_enb}, 32'd3);
    check({tag, "_acc_id_enb"},{30'd0, intf.access_enb, intf.id_enb}, 32'd3);
    check({tag, "_multi_enb"}, {31'd0, intf.multi_enb}, 32'd1);
    check({tag, "_code"},      {29'd0, intf.code_d}, {29'd0, code});
    check({tag, "_access"},    {31'd0, intf.access_d}, {31'd0, acc});
    check({tag, "_id"},        {26'd0, intf.id_d}, {26'd0, id});
    check({tag, "_data"},      intf.data_d, data);
    check({tag, "_group"},     {28'd0, intf.group_idx_d}, {28'd0, grp});
    check({tag, "_slice"},     {27'd0, intf.slice_idx_d}, {27'd0, slice});
    check({tag, "_multi_d"},   {31'd0, intf.multi_d}, {31'd0, multi});
  endtask

  function automatic logic [31:0] any_enb();
    return {25'd0, intf.code_enb, intf.access_enb, intf.id_enb, intf.multi_enb,
            intf.data_enb, intf.slice_idx_enb, intf.group_idx_enb};
  endfunction

  initial begin
    rst = 1'b1;
    cnt_clr = 1'b0;
    intf.code_q = 3'd0;
    intf.multi_q = 1'b0;
    clear_err();
    tick();
    tick();
    check("rst_enables", any_enb(), 32'd0);
    check("rst_data_d", intf.data_d, 32'd0);
    check("rst_cnt", {16'd0, err_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // single error on slice 3
    set_err(3, 3'd2, 1'b1, 6'h15, 32'hDEADBEEF, 4'd5);
    tick();
    clear_err();
    check_capture("single", 3'd2, 1'b1, 6'h15, 32'hDEADBEEF, 4'd5, 5'd3, 1'b0);
    check("single_cnt", {16'd0, err_cnt}, 32'd1);
    tick();
    check("single_pulse_len", any_enb(), 32'd0);
    intf.code_q = 3'd2;
    tick();
    check("wait_to_full", any_enb(), 32'd0);

    // error while FULL with multi_q=0, then again with multi_q=1
    set_err(4, 3'd1, 1'b0, 6'h01, 32'h1, 4'd1);
    tick();
    clear_err();
    check("full_multi_enb", any_enb(), 32'h08);
    check("full_multi_d", {31'd0, intf.multi_d}, 32'd1);
    check("full_cnt", {16'd0, err_cnt}, 32'd2);
    intf.multi_q = 1'b1;
    tick();
    check("full_multi_one", any_enb(), 32'd0);
    set_err(5, 3'd1, 1'b0, 6'h02, 32'h2, 4'd2);
    tick();
    clear_err();
    check("full_multi_q_nowrite", any_enb(), 32'd0);
    check("full_cnt2", {16'd0, err_cnt}, 32'd3);

    // software clear together with error on slice 9 carrying code 0
    intf.code_q = 3'd0;
    intf.multi_q = 1'b0;
    set_err(9, 3'd0, 1'b0, 6'h2A, 32'h12345678, 4'hA);
    tick();
    clear_err();
    check_capture("swclr", 3'd7, 1'b0, 6'h2A, 32'h12345678, 4'hA, 5'd9, 1'b0);
    check("swclr_cnt", {16'd0, err_cnt}, 32'd4);

    // error arriving in WAIT before code_q updates
    set_err(1, 3'd3, 1'b1, 6'h03, 32'h3, 4'd3);
    tick();
    clear_err();
    check("wait_err_nowrite", any_enb(), 32'd0);
    check("wait_cnt", {16'd0, err_cnt}, 32'd5);
    intf.code_q = 3'd7;
    tick();
    check("wait_enter_full", any_enb(), 32'd0);
    tick();
    check("pend_multi_enb", any_enb(), 32'h08);
    check("pend_multi_d", {31'd0, intf.multi_d}, 32'd1);
    tick();
    check("pend_single_pulse", any_enb(), 32'd0);
    intf.multi_q = 1'b1;

    // clear to IDLE, then simultaneous errors on slices 7 and 2
    intf.code_q = 3'd0;
    tick();
    check("idle_quiet", any_enb(), 32'd0);
    set_err(7, 3'd4, 1'b1, 6'h07, 32'h77777777, 4'd7);
    set_err(2, 3'd5, 1'b0, 6'h22, 32'hCAFEF00D, 4'd2);
    tick();
    clear_err();
    check_capture("dual", 3'd5, 1'b0, 6'h22, 32'hCAFEF00D, 4'd2, 5'd2, 1'b1);
    check("dual_cnt", {16'd0, err_cnt}, 32'd7);

    // reset with the log still occupied: adopt it without writing
    intf.code_q = 3'd5;
    intf.multi_q = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_cnt", {16'd0, err_cnt}, 32'd0);
    set_err(0, 3'd6, 1'b1, 6'h3F, 32'hFFFF0000, 4'hF);
    tick();
    clear_err();
    check("rst_occupied_nowrite", any_enb(), 32'd0);
    tick();
    check("rst_occupied_multi", any_enb(), 32'h08);
    intf.multi_q = 1'b1;

    // counter saturation and clear priority
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("cnt_clr", {16'd0, err_cnt}, 32'd0);
    intf.err_vld = '1;
    repeat (2047) tick();
    intf.err_vld = 32'h3FFF_FFFF;
    tick();
    check("cnt_fffe", {16'd0, err_cnt}, 32'hFFFE);
    intf.err_vld = 32'h0000_0007;
    tick();
    check("cnt_sat", {16'd0, err_cnt}, 32'hFFFF);
    intf.err_vld = 32'h0000_0001;
    tick();
    check("cnt_hold", {16'd0, err_cnt}, 32'hFFFF);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    intf.err_vld = '0;
    check("cnt_clr_prio", {16'd0, err_cnt}, 32'd0);
    tick();
    check("cnt_after_clr", {16'd0, err_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
